execute_md: RTL and testbench
=============================

Name: execute_md

Overview:
- Parametrised execute stage for the RISC-V pipeline: D->E pipeline register, operand forwarding muxes, single-cycle ALU, and an iterative RV32M-style multiply/divide unit.
- The multiply/divide unit holds the stage and stalls upstream until its result is ready.
- Sits between decode and memory stages.
- Drives the hazard unit with rs1/rs2 and a stall request.

Parameters:
- XLEN, 32, datapath width (>=8, even).
- REG_AW, 5, register-address width.
- CNT_W, $clog2(XLEN)+1, iteration counter width.

Ports:
- clk  input  1  clock, rising edge.
- clr  input  1  asynchronous, active-high reset.
- i_flush_E  input  1  synchronous flush: loads a bubble into E and aborts any mul/div.
- i_s1_D, i_s2_D  input  XLEN  register operands.
- i_rd_D, i_rs1_D, i_rs2_D  input  REG_AW  register addresses.
- i_imm_D  input  XLEN  sign-extended immediate.
- i_rf_wr_en_D, i_dm_wr_en_D, i_sel_srcB_D, i_sel_result_D  input  1  control.
- i_ALU_ctrl_D  input  4  ALU op.
- i_md_en_D  input  1  instruction is mul/div.
- i_md_op_D  input  3  funct3 code: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- i_ALU_output_M, i_result_W  input  XLEN  forwarded values.
- i_fwdA_E, i_fwdB_E  input  2  forward select: 00 reg, 01 W, 1x M.
- o_rf_wr_addr_E  output  REG_AW  rd.
- o_ALU_output_E  output  XLEN  ALU or mul/div result.
- o_wr_data_E  output  XLEN  forwarded s2.
- o_rf_wr_en_E, o_dm_wr_en_E, o_sel_result_E  output  1  registered control.
- o_rs1_E, o_rs2_E  output  REG_AW  registered source addresses.
- o_stall_E  output  1  hold F/D/E; M receives a bubble.

Behaviour:
- Reset (clr=1, async): all E registers 0; o_rf_wr_en_E=0, o_dm_wr_en_E=0, o_stall_E=0; FSM=IDLE; counter=0.
- E register update, per clock, in priority order:
  - i_flush_E: load a bubble (all control 0, data 0).
  - o_stall_E: hold.
  - Otherwise: capture the D inputs.
- srcA = fwd(s1); wr_data = fwd(s2); srcB = sel_srcB ? imm : wr_data.
- ALU_ctrl encoding: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA; 10-15 give 0.
  - Shift amount is srcB[$clog2(XLEN)-1:0].
  - Add/sub wrap modulo 2^XLEN.
- FSM states: IDLE, RUN, DONE.
- IDLE: if the E register holds md_en=1 and no flush:
  - Latch srcA/srcB (post-forwarding) and md_op.
  - Raise o_stall_E combinationally this cycle.
  - Load counter=XLEN and go to RUN.
  - Exception: div-by-zero or signed overflow goes directly to DONE.
- RUN: one shift-add (multiply) or restoring-subtract (divide) step per cycle.
  - Operands are processed on magnitudes; sign is fixed up at the end.
  - Counter decrements each cycle; at counter==1 go to DONE.
  - o_stall_E=1 throughout.
- DONE: o_stall_E=0; o_ALU_output_E = md result; next cycle return to IDLE as the instruction leaves E.
- Stall length for a normal mul/div: entry cycle + XLEN RUN cycles = XLEN+1 cycles. The result is visible in cycle XLEN+2 after entry.
- Result selection:
  - MUL: low XLEN bits of the product.
  - MULH/MULHSU/MULHU: high XLEN bits of the signed×signed, signed×unsigned, unsigned×unsigned product.
- Divide by zero: quotient = all ones; remainder = dividend. Result in DONE with 1 stall cycle.
- Signed overflow (DIV/REM of -2^(XLEN-1) by -1): quotient = dividend; remainder = 0. Result in DONE with 1 stall cycle.
- i_flush_E in any state: FSM->IDLE, o_stall_E=0 next cycle, E gets a bubble; the partial result is discarded.
- Non-md instructions (md_en=0): o_ALU_output_E = ALU result; no stall.
- Back-to-back md instructions: the second enters E the cycle after DONE and starts a fresh IDLE->RUN; there is no idle gap.
- clr asserted mid-operation: immediate return to reset state.

Test Plan:
- ADD with fwdA=01, i_result_W=0x10, srcB=imm 0x5 -> o_ALU_output_E=0x15 in the same cycle as E; o_stall_E=0.
- MUL 0xFFFFFFFF × 0x2 (XLEN=32) -> o_stall_E high exactly 33 cycles, then o_ALU_output_E=0xFFFFFFFE. MULHU on the same operands -> 0x1; MULH -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; both after a 33-cycle stall.
- DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 0x5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; each with exactly 1 stall cycle.
- Flush asserted in RUN iteration 10 -> o_stall_E=0 next cycle; o_rf_wr_en_E=0; the next ADD proceeds normally.
- clr pulsed asynchronously mid-RUN -> outputs 0 and o_stall_E=0 immediately; after release, a MUL 3×4 yields 0xC.

Source files
------------

// File: rtl/execute_md_if.sv
// Execute-stage bus: decode-side inputs, forwarding inputs and E-stage outputs.
// The master drives the D/forwarding side; execute_md is the slave.
interface execute_md_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    logic              i_flush_E;
    logic [XLEN-1:0]   i_s1_D;
    logic [XLEN-1:0]   i_s2_D;
    logic [REG_AW-1:0] i_rd_D;
    logic [REG_AW-1:0] i_rs1_D;
    logic [REG_AW-1:0] i_rs2_D;
    logic [XLEN-1:0]   i_imm_D;
    logic              i_rf_wr_en_D;
    logic              i_dm_wr_en_D;
    logic              i_sel_srcB_D;
    logic              i_sel_result_D;
    logic [3:0]        i_ALU_ctrl_D;
    logic              i_md_en_D;
    logic [2:0]        i_md_op_D;
    logic [XLEN-1:0]   i_ALU_output_M;
    logic [XLEN-1:0]   i_result_W;
    logic [1:0]        i_fwdA_E;
    logic [1:0]        i_fwdB_E;

    logic [REG_AW-1:0] o_rf_wr_addr_E;
    logic [XLEN-1:0]   o_ALU_output_E;
    logic [XLEN-1:0]   o_wr_data_E;
    logic              o_rf_wr_en_E;
    logic              o_dm_wr_en_E;
    logic              o_sel_result_E;
    logic [REG_AW-1:0] o_rs1_E;
    logic [REG_AW-1:0] o_rs2_E;
    logic              o_stall_E;

    modport master (
        output i_flush_E, i_s1_D, i_s2_D, i_rd_D, i_rs1_D, i_rs2_D, i_imm_D,
               i_rf_wr_en_D, i_dm_wr_en_D, i_sel_srcB_D, i_sel_result_D,
               i_ALU_ctrl_D, i_md_en_D, i_md_op_D, i_ALU_output_M, i_result_W,
               i_fwdA_E, i_fwdB_E,
        input  o_rf_wr_addr_E, o_ALU_output_E, o_wr_data_E, o_rf_wr_en_E,
               o_dm_wr_en_E, o_sel_result_E, o_rs1_E, o_rs2_E, o_stall_E
    );

    modport slave (
        input  i_flush_E, i_s1_D, i_s2_D, i_rd_D, i_rs1_D, i_rs2_D, i_imm_D,
               i_rf_wr_en_D, i_dm_wr_en_D, i_sel_srcB_D, i_sel_result_D,
               i_ALU_ctrl_D, i_md_en_D, i_md_op_D, i_ALU_output_M, i_result_W,
               i_fwdA_E, i_fwdB_E,
        output o_rf_wr_addr_E, o_ALU_output_E, o_wr_data_E, o_rf_wr_en_E,
               o_dm_wr_en_E, o_sel_result_E, o_rs1_E, o_rs2_E, o_stall_E
    );
endinterface

// File: rtl/execute_md.sv
// RISC-V execute stage: D->E register, forwarding muxes, single-cycle ALU and
// an iterative shift-add multiplier / restoring divider that stalls the stage.
module execute_md #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = $clog2(XLEN) + 1
) (
    input  logic         clk,
    input  logic         clr,
    execute_md_if.slave  bus
);
    localparam int SHW = $clog2(XLEN);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    // E pipeline register
    logic              rf_wr_en_q, dm_wr_en_q, sel_srcB_q, sel_result_q, md_en_q;
    logic [3:0]        alu_ctrl_q;
    logic [2:0]        md_op_q;
    logic [XLEN-1:0]   s1_q, s2_q, imm_q;
    logic [REG_AW-1:0] rd_q, rs1_q, rs2_q;

    // Datapath
    logic [XLEN-1:0]   src_a, src_b, wr_data, alu_result;
    logic [SHW-1:0]    shamt;

    // Mul/div unit
    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [XLEN-1:0]   hi_q, lo_q, opd_q;
    logic [2:0]        op_q;
    logic              neg_q, rneg_q;
    logic              stall;

    logic              is_div, a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [XLEN-1:0]   hi_n, lo_n;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   q_fix, r_fix, md_result;

    // D->E register: flush loads a bubble, stall holds, otherwise capture D
    always_ff @(posedge clk or posedge clr) begin
        if (clr || bus.i_flush_E) begin
            rf_wr_en_q   <= 1'b0;
            dm_wr_en_q   <= 1'b0;
            sel_srcB_q   <= 1'b0;
            sel_result_q <= 1'b0;
            md_en_q      <= 1'b0;
            alu_ctrl_q   <= '0;
            md_op_q      <= '0;
            s1_q         <= '0;
            s2_q         <= '0;
            imm_q        <= '0;
            rd_q         <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
        end else if (!stall) begin
            rf_wr_en_q   <= bus.i_rf_wr_en_D;
            dm_wr_en_q   <= bus.i_dm_wr_en_D;
            sel_srcB_q   <= bus.i_sel_srcB_D;
            sel_result_q <= bus.i_sel_result_D;
            md_en_q      <= bus.i_md_en_D;
            alu_ctrl_q   <= bus.i_ALU_ctrl_D;
            md_op_q      <= bus.i_md_op_D;
            s1_q         <= bus.i_s1_D;
            s2_q         <= bus.i_s2_D;
            imm_q        <= bus.i_imm_D;
            rd_q         <= bus.i_rd_D;
            rs1_q        <= bus.i_rs1_D;
            rs2_q        <= bus.i_rs2_D;
        end
    end

    // Operand forwarding: 00 register file, 01 writeback, 1x memory stage
    always_comb begin
        case (bus.i_fwdA_E)
            2'b00:   src_a = s1_q;
            2'b01:   src_a = bus.i_result_W;
            default: src_a = bus.i_ALU_output_M;
        endcase
        case (bus.i_fwdB_E)
            2'b00:   wr_data = s2_q;
            2'b01:   wr_data = bus.i_result_W;
            default: wr_data = bus.i_ALU_output_M;
        endcase
        src_b = sel_srcB_q ? imm_q : wr_data;
        shamt = src_b[SHW-1:0];
    end

    // Single-cycle ALU
    always_comb begin
        case (alu_ctrl_q)
            4'd0:    alu_result = src_a + src_b;
            4'd1:    alu_result = src_a - src_b;
            4'd2:    alu_result = src_a & src_b;
            4'd3:    alu_result = src_a | src_b;
            4'd4:    alu_result = src_a ^ src_b;
            4'd5:    alu_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            4'd6:    alu_result = {{(XLEN-1){1'b0}}, (src_a < src_b)};
            4'd7:    alu_result = src_a << shamt;
            4'd8:    alu_result = src_a >> shamt;
            4'd9:    alu_result = $unsigned($signed(src_a) >>> shamt);
            default: alu_result = '0;
        endcase
    end

    // Operand signedness, magnitudes and divide special cases at entry
    always_comb begin
        is_div   = md_op_q[2];
        a_sgn    = is_div ? ~md_op_q[0] : (md_op_q != 3'd3);
        b_sgn    = is_div ? ~md_op_q[0] : ~md_op_q[1];
        a_neg    = a_sgn & src_a[XLEN-1];
        b_neg    = b_sgn & src_b[XLEN-1];
        a_mag    = a_neg ? -src_a : src_a;
        b_mag    = b_neg ? -src_b : src_b;
        div_zero = is_div & (src_b == '0);
        div_ovf  = is_div & ~md_op_q[0] & (src_a == MIN_NEG) & (src_b == '1);
    end

    // One iteration: hi:lo is product/multiplier for mul, remainder:quotient for div
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, opd_q};
        if (op_q[2]) begin
            if (!div_diff[XLEN]) begin
                hi_n = div_diff[XLEN-1:0];
                lo_n = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                hi_n = div_shift[XLEN-1:0];
                lo_n = {lo_q[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_n = mul_sum[XLEN:1];
            lo_n = {mul_sum[0], lo_q[XLEN-1:1]};
        end
    end

    // Sign fix-up and result selection
    always_comb begin
        prod     = {hi_q, lo_q};
        prod_fix = neg_q ? -prod : prod;
        q_fix    = neg_q ? -lo_q : lo_q;
        r_fix    = rneg_q ? -hi_q : hi_q;
        case (op_q)
            3'd0:       md_result = prod_fix[XLEN-1:0];
            3'd1, 3'd2,
            3'd3:       md_result = prod_fix[2*XLEN-1:XLEN];
            3'd4, 3'd5: md_result = q_fix;
            default:    md_result = r_fix;
        endcase
    end

    // Mul/div sequencer: IDLE latches operands, RUN iterates, DONE presents result
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state  <= S_IDLE;
            cnt    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            opd_q  <= '0;
            op_q   <= '0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
        end else if (bus.i_flush_E) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (md_en_q) begin
                        op_q <= md_op_q;
                        // Special divide cases bypass iteration; results are
                        // preloaded raw so the fix-up stage leaves them alone.
                        if (div_zero) begin
                            hi_q   <= src_a;
                            lo_q   <= '1;
                            neg_q  <= 1'b0;
                            rneg_q <= 1'b0;
                            state  <= S_DONE;
                        end else if (div_ovf) begin
                            hi_q   <= '0;
                            lo_q   <= src_a;
                            neg_q  <= 1'b0;
                            rneg_q <= 1'b0;
                            state  <= S_DONE;
                        end else begin
                            hi_q   <= '0;
                            lo_q   <= is_div ? a_mag : b_mag;
                            opd_q  <= is_div ? b_mag : a_mag;
                            neg_q  <= a_neg ^ b_neg;
                            rneg_q <= a_neg;
                            cnt    <= CNT_W'(XLEN);
                            state  <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    hi_q <= hi_n;
                    lo_q <= lo_n;
                    cnt  <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state <= S_DONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Stall on mul/div entry (unless flushed) and for every iteration
    always_comb begin
        stall = (state == S_RUN) ||
                ((state == S_IDLE) && md_en_q && !bus.i_flush_E);
    end

    assign bus.o_rf_wr_addr_E = rd_q;
    assign bus.o_ALU_output_E = (state == S_DONE) ? md_result : alu_result;
    assign bus.o_wr_data_E    = wr_data;
    assign bus.o_rf_wr_en_E   = rf_wr_en_q;
    assign bus.o_dm_wr_en_E   = dm_wr_en_q;
    assign bus.o_sel_result_E = sel_result_q;
    assign bus.o_rs1_E        = rs1_q;
    assign bus.o_rs2_E        = rs2_q;
    assign bus.o_stall_E      = stall;

endmodule

// File: tb/tb_execute_md.sv
// Scoreboard bench for execute_md: the driver queues the expected result and
// stall length of each instruction; a negedge monitor checks every retirement.
module tb_execute_md;
    localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2, A_OR = 4'd3,
                           A_XOR = 4'd4, A_SLT = 4'd5, A_SLTU = 4'd6, A_SLL = 4'd7,
                           A_SRL = 4'd8, A_SRA = 4'd9;
    localparam logic [2:0] M_MUL = 3'd0, M_MULH = 3'd1, M_MULHSU = 3'd2, M_MULHU = 3'd3,
                           M_DIV = 3'd4, M_DIVU = 3'd5, M_REM = 3'd6, M_REMU = 3'd7;

    typedef struct {
        int          id;
        logic [4:0]  rd;
        logic [31:0] val;
        int          stalls;
    } exp_t;

    logic clk;
    logic clr;
    exp_t sb[$];
    int   vectors;
    int   miscompares;
    int   stall_cnt;
    int   next_id;

    execute_md_if #(.XLEN(32), .REG_AW(5)) bus ();

    execute_md #(.XLEN(32), .REG_AW(5)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: count stall cycles, compare each instruction as it leaves E
    always @(negedge clk) begin
        exp_t e;
        if (clr) begin
            stall_cnt = 0;
        end else if (bus.o_stall_E) begin
            stall_cnt++;
        end else if (bus.o_rf_wr_en_E) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_retire rd=%0d: result=%h with no pending expectation",
                         bus.o_rf_wr_addr_E, bus.o_ALU_output_E);
            end else begin
                e = sb.pop_front();
                if (bus.o_ALU_output_E !== e.val || bus.o_rf_wr_addr_E !== e.rd ||
                    stall_cnt != e.stalls) begin
                    miscompares++;
                    $display("FAIL vec%0d: result=%h rd=%0d stalls=%0d, expected result=%h rd=%0d stalls=%0d",
                             e.id, bus.o_ALU_output_E, bus.o_rf_wr_addr_E, stall_cnt,
                             e.val, e.rd, e.stalls);
                end
            end
            stall_cnt = 0;
        end else begin
            stall_cnt = 0;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic set_nop();
        bus.i_s1_D         = '0;
        bus.i_s2_D         = '0;
        bus.i_imm_D        = '0;
        bus.i_rd_D         = '0;
        bus.i_rs1_D        = '0;
        bus.i_rs2_D        = '0;
        bus.i_rf_wr_en_D   = 1'b0;
        bus.i_dm_wr_en_D   = 1'b0;
        bus.i_sel_srcB_D   = 1'b0;
        bus.i_sel_result_D = 1'b0;
        bus.i_ALU_ctrl_D   = A_ADD;
        bus.i_md_en_D      = 1'b0;
        bus.i_md_op_D      = '0;
    endtask

    // Present one instruction in D and hold it until E captures it
    task automatic issue(input logic [3:0] alu, input logic md, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                         input logic selb, input logic [4:0] rd,
                         input logic [31:0] exp, input int stalls, input bit push);
        bit st;
        int guard;
        bus.i_s1_D         = a;
        bus.i_s2_D         = b;
        bus.i_imm_D        = imm;
        bus.i_rd_D         = rd;
        bus.i_rs1_D        = rd + 5'd1;
        bus.i_rs2_D        = rd + 5'd2;
        bus.i_rf_wr_en_D   = 1'b1;
        bus.i_dm_wr_en_D   = 1'b0;
        bus.i_sel_srcB_D   = selb;
        bus.i_sel_result_D = 1'b0;
        bus.i_ALU_ctrl_D   = alu;
        bus.i_md_en_D      = md;
        bus.i_md_op_D      = op;
        if (push) begin
            sb.push_back('{next_id, rd, exp, stalls});
            next_id++;
        end
        guard = 0;
        do begin
            st = bus.o_stall_E;
            @(posedge clk);
            #1;
            guard++;
        end while (st && guard < 100);
        if (st) begin
            vectors++;
            miscompares++;
            $display("FAIL issue_timeout rd=%0d: stall still %0d after %0d cycles, expected 0",
                     rd, st, guard);
        end
        set_nop();
    endtask

    task automatic nop_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int g;
        vectors     = 0;
        miscompares = 0;
        stall_cnt   = 0;
        next_id     = 0;
        clr         = 1'b1;
        bus.i_flush_E      = 1'b0;
        bus.i_fwdA_E       = 2'b00;
        bus.i_fwdB_E       = 2'b00;
        bus.i_ALU_output_M = '0;
        bus.i_result_W     = '0;
        set_nop();

        #23;
        check("reset_stall",    {31'd0, bus.o_stall_E},    32'd0);
        check("reset_rf_wr_en", {31'd0, bus.o_rf_wr_en_E}, 32'd0);
        check("reset_dm_wr_en", {31'd0, bus.o_dm_wr_en_E}, 32'd0);
        check("reset_rd",       {27'd0, bus.o_rf_wr_addr_E}, 32'd0);
        check("reset_result",   bus.o_ALU_output_E,        32'd0);
        #4 clr = 1'b0;
        @(posedge clk);
        #1;

        // Forwarding from W into srcA, immediate as srcB
        bus.i_fwdA_E   = 2'b01;
        bus.i_result_W = 32'h10;
        issue(A_ADD, 0, 0, 32'h999, 32'h0, 32'h5, 1, 5'd1, 32'h15, 0, 1);
        check("fwdW_rs1", {27'd0, bus.o_rs1_E}, 32'd2);
        nop_cycle();
        bus.i_fwdA_E   = 2'b00;
        bus.i_result_W = '0;

        // Forwarding from M into srcB / store data
        bus.i_fwdB_E       = 2'b10;
        bus.i_ALU_output_M = 32'h100;
        issue(A_ADD, 0, 0, 32'h23, 32'hDEAD, 32'h0, 0, 5'd2, 32'h123, 0, 1);
        check("fwdM_wr_data", bus.o_wr_data_E, 32'h100);
        nop_cycle();
        bus.i_fwdB_E       = 2'b00;
        bus.i_ALU_output_M = '0;

        // ALU operations
        issue(A_SUB,  0, 0, 32'h5,        32'h7,        0,     0, 5'd3,  32'hFFFF_FFFE, 0, 1);
        issue(A_AND,  0, 0, 32'hF0F0_1234, 32'h0FF0_FF00, 0,   0, 5'd4,  32'h00F0_1200, 0, 1);
        issue(A_OR,   0, 0, 32'hF000_0000, 32'h0000_000F, 0,   0, 5'd5,  32'hF000_000F, 0, 1);
        issue(A_XOR,  0, 0, 32'hFFFF_0000, 32'h0F0F_0F0F, 0,   0, 5'd6,  32'hF0F0_0F0F, 0, 1);
        issue(A_SLT,  0, 0, 32'hFFFF_FFFF, 32'h1,        0,     0, 5'd7,  32'h1,         0, 1);
        issue(A_SLTU, 0, 0, 32'hFFFF_FFFF, 32'h1,        0,     0, 5'd8,  32'h0,         0, 1);
        issue(A_SLL,  0, 0, 32'h1,        32'h0,        32'h23, 1, 5'd9,  32'h8,         0, 1);
        issue(A_SRL,  0, 0, 32'h8000_0000, 32'h4,        0,     0, 5'd10, 32'h0800_0000, 0, 1);
        issue(A_SRA,  0, 0, 32'h8000_0000, 32'h4,        0,     0, 5'd11, 32'hF800_0000, 0, 1);
        issue(4'd12,  0, 0, 32'h5,        32'h6,        0,     0, 5'd12, 32'h0,         0, 1);

        // Multiply, back-to-back
        issue(A_ADD, 1, M_MUL,    32'hFFFF_FFFF, 32'h2,        0, 0, 5'd13, 32'hFFFF_FFFE, 33, 1);
        issue(A_ADD, 1, M_MULHU,  32'hFFFF_FFFF, 32'h2,        0, 0, 5'd14, 32'h1,         33, 1);
        issue(A_ADD, 1, M_MULH,   32'hFFFF_FFFF, 32'h2,        0, 0, 5'd15, 32'hFFFF_FFFF, 33, 1);
        issue(A_ADD, 1, M_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 5'd16, 32'hFFFF_FFFF, 33, 1);
        issue(A_ADD, 1, M_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 5'd17, 32'hFFFF_FFFE, 33, 1);
        issue(A_ADD, 1, M_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 5'd18, 32'h0,         33, 1);

        // Divide / remainder
        issue(A_ADD, 1, M_DIV,  32'hFFFF_FFF9, 32'h2,        0, 0, 5'd19, 32'hFFFF_FFFD, 33, 1);
        issue(A_ADD, 1, M_REM,  32'hFFFF_FFF9, 32'h2,        0, 0, 5'd20, 32'hFFFF_FFFF, 33, 1);
        issue(A_ADD, 1, M_DIV,  32'h7,         32'hFFFF_FFFE, 0, 0, 5'd21, 32'hFFFF_FFFD, 33, 1);
        issue(A_ADD, 1, M_REM,  32'h7,         32'hFFFF_FFFE, 0, 0, 5'd22, 32'h1,         33, 1);
        issue(A_ADD, 1, M_DIVU, 32'd100,       32'd7,        0, 0, 5'd23, 32'd14,        33, 1);
        issue(A_ADD, 1, M_REMU, 32'd100,       32'd7,        0, 0, 5'd24, 32'd2,         33, 1);

        // Divide by zero and signed overflow: single stall cycle
        issue(A_ADD, 1, M_DIVU, 32'h5,         32'h0,        0, 0, 5'd25, 32'hFFFF_FFFF, 1, 1);
        issue(A_ADD, 1, M_REMU, 32'h5,         32'h0,        0, 0, 5'd26, 32'h5,         1, 1);
        issue(A_ADD, 1, M_DIV,  32'h5,         32'h0,        0, 0, 5'd27, 32'hFFFF_FFFF, 1, 1);
        issue(A_ADD, 1, M_REM,  32'hFFFF_FFF9, 32'h0,        0, 0, 5'd28, 32'hFFFF_FFF9, 1, 1);
        issue(A_ADD, 1, M_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 5'd29, 32'h8000_0000, 1, 1);
        issue(A_ADD, 1, M_REM,  32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 5'd30, 32'h0,         1, 1);

        // Flush in RUN iteration 10
        issue(A_ADD, 1, M_MUL, 32'd7, 32'd9, 0, 0, 5'd31, 32'd63, 33, 0);
        check("flush_entry_stall", {31'd0, bus.o_stall_E}, 32'd1);
        repeat (10) @(posedge clk);
        #1;
        bus.i_flush_E = 1'b1;
        check("flush_run_stall", {31'd0, bus.o_stall_E}, 32'd1);
        @(posedge clk);
        #1;
        bus.i_flush_E = 1'b0;
        check("flush_next_stall",    {31'd0, bus.o_stall_E},    32'd0);
        check("flush_next_rf_wr_en", {31'd0, bus.o_rf_wr_en_E}, 32'd0);
        issue(A_ADD, 0, 0, 32'h1, 32'h2, 0, 0, 5'd3, 32'h3, 0, 1);

        // Asynchronous clear mid-RUN
        issue(A_ADD, 1, M_MUL, 32'd100, 32'd200, 0, 0, 5'd4, 32'd20000, 33, 0);
        repeat (5) @(posedge clk);
        #2 clr = 1'b1;
        #1;
        check("clr_result",   bus.o_ALU_output_E,        32'd0);
        check("clr_stall",    {31'd0, bus.o_stall_E},    32'd0);
        check("clr_rf_wr_en", {31'd0, bus.o_rf_wr_en_E}, 32'd0);
        #3 clr = 1'b0;
        @(posedge clk);
        #1;
        issue(A_ADD, 1, M_MUL, 32'd3, 32'd4, 0, 0, 5'd5, 32'hC, 33, 1);

        g = 0;
        while (sb.size() != 0 && g < 100) begin
            @(posedge clk);
            g++;
        end
        #1;
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d results still pending, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end
endmodule
